param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits (WIDTH >= 2).
REQ-002 SHALL provide parameter MAX_VAL, default 2**WIDTH-1, upper count limit (1 <= MAX_VAL <= 2**WIDTH-1).
REQ-003 SHALL provide parameter SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL provide port en  input  1  count enable.
REQ-007 SHALL provide port up_down  input  1  direction; 1 = up, 0 = down.
REQ-008 SHALL provide port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL provide port load_val  input  WIDTH  value to load.
REQ-010 SHALL provide port q  output  WIDTH  registered count.
REQ-011 SHALL provide port tc  output  1  combinational terminal count.
REQ-012 SHALL provide port ovf  output  1  registered one-cycle pulse on an up-step at MAX_VAL.
REQ-013 SHALL provide port unf  output  1  registered one-cycle pulse on a down-step at 0.

Function
REQ-014 SHALL apply per-edge priority: rst low > load high > en high > hold.
REQ-015 SHALL on load set q to load_val when load_val <= MAX_VAL, else to MAX_VAL; ovf/unf low that cycle; en and up_down ignored.
REQ-016 SHALL with en=1, load=0, up_down=1, q<MAX_VAL set q to q+1 on the next edge.
REQ-017 SHALL with en=1, load=0, up_down=0, q>0 set q to q-1 on the next edge.
REQ-018 SHALL on an up-step at q=MAX_VAL set q to 0 (SATURATE=0) or hold MAX_VAL (SATURATE=1), and assert ovf on the next cycle for exactly one cycle in both modes.
REQ-019 SHALL on a down-step at q=0 set q to MAX_VAL (SATURATE=0) or hold 0 (SATURATE=1), and assert unf on the next cycle for exactly one cycle in both modes.
REQ-020 SHALL drive tc = en & ~load & ((up_down & q==MAX_VAL) | (~up_down & q==0)), zero latency.
REQ-021 SHALL with en=0 and load=0 hold q and deassert ovf and unf.
REQ-022 SHALL take the direction change effect on the same edge the new up_down value is sampled; no dead cycle.
REQ-023 SHALL keep ovf and unf mutually exclusive and sustain pulses on consecutive wrap events when MAX_VAL=1 or repeated saturation (one pulse per enabled edge at a limit).
REQ-024 SHALL never produce q > MAX_VAL in any sequence of inputs after reset.
REQ-025 SHALL use pure binary arithmetic modulo MAX_VAL+1; no out-of-range intermediate state visible on q.

Reset
REQ-026 SHALL on any rising edge with rst=0 set q=0, ovf=0, unf=0, regardless of load/en.
REQ-027 SHALL leave outputs uncontrolled until the first reset edge; no asynchronous reset path.
REQ-028 SHALL on reset asserted mid-count discard the in-progress step and any pending ovf/unf pulse.
REQ-029 SHALL resume counting from 0 on the first edge after rst returns high with en=1.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-030 SHALL cover: rst=0 two edges, load=1, en=1 -> q=0, ovf=unf=0; release, up, 12 edges -> q=1,2,...,9,0,1,2; ovf high exactly the cycle after q 9->0.
REQ-031 SHALL cover: from q=2, up_down=0, 4 edges -> q=1,0,9,8; tc high while q=0; unf high one cycle after 0->9.
REQ-032 SHALL cover: SATURATE=1, from q=8 up 3 edges -> q=9,9,9, ovf high on the 2 cycles after each at-limit step; then down from 0 -> q holds 0, unf pulses.
REQ-033 SHALL cover: load=1 load_val=13 with en=1 -> q=9; load_val=5 with en=1 up -> q=5 (load wins), tc=0 during load.
REQ-034 SHALL cover: count to q=9 with en=1 up, assert rst=0 on that edge -> q=0, no ovf; en=0 three edges -> q holds, tc=0.
REQ-035 SHALL cover: WIDTH=8, MAX_VAL=255, SATURATE=0 random en/up_down/load 10k cycles against a reference model -> exact match of q, tc, ovf, unf each cycle.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter bounded by MAX_VAL, with parallel load,
// wrap-or-saturate behaviour at the limits and registered overflow/underflow pulses.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic at_max;
    logic at_zero;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == ZERO_Q);

    // Combinational: a load on this edge suppresses the terminal-count indication.
    assign tc = en & ~load & ((up_down & at_max) | (~up_down & at_zero));

    always_ff @(posedge clk) begin
        if (!rst) begin
            q   <= ZERO_Q;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (load) begin
            q   <= (load_val > MAX_Q) ? MAX_Q : load_val;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (en) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (up_down) begin
                if (at_max) begin
                    q   <= SATURATE ? MAX_Q : ZERO_Q;
                    ovf <= 1'b1;
                end else begin
                    q <= q + ONE_Q;
                end
            end else begin
                if (at_zero) begin
                    q   <= SATURATE ? ZERO_Q : MAX_Q;
                    unf <= 1'b1;
                end else begin
                    q <= q - ONE_Q;
                end
            end
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: a wrapping and a saturating WIDTH=4/MAX_VAL=9 counter plus an
// 8-bit full-range counter, all driven by the same stimulus sequence.
module tb_param_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] load_val;

    logic [3:0] q0, q1;
    logic [7:0] q2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;
    logic       unf0, unf1, unf2;

    int checks = 0;
    int errors = 0;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[3:0]), .q(q0), .tc(tc0), .ovf(ovf0), .unf(unf0)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val[3:0]), .q(q1), .tc(tc1), .ovf(ovf1), .unf(unf1)
    );

    param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_wide (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .q(q2), .tc(tc2), .ovf(ovf2), .unf(unf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; load = 1'b1; en = 1'b1; up_down = 1'b1; load_val = 8'd5;

        // Reset dominates load and enable.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_q0", q0, 0);
            check("rst_q1", q1, 0);
            check("rst_q2", q2, 0);
            check("rst_ovf0", ovf0, 0);
            check("rst_unf0", unf0, 0);
        end

        // Count up 12 edges.
        rst = 1'b1; load = 1'b0; en = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("up_q0", q0, i % 10);
            check("up_ovf0", ovf0, (i == 10) ? 1 : 0);
            check("up_tc0", tc0, ((i % 10) == 9) ? 1 : 0);
            check("up_q1", q1, (i > 9) ? 9 : i);
            check("up_ovf1", ovf1, (i >= 10) ? 1 : 0);
            check("up_tc1", tc1, (i >= 9) ? 1 : 0);
            check("up_q2", q2, i);
            check("up_ovf2", ovf2, 0);
        end

        // Direction change takes effect immediately: q0 2,1,0,9,8.
        up_down = 1'b0;
        #1;
        check("dn_tc0_q2", tc0, 0);
        step(); check("dn_q0_1", q0, 1); check("dn_unf0_1", unf0, 0); check("dn_q1_1", q1, 8);
        step(); check("dn_q0_2", q0, 0); check("dn_tc0_2", tc0, 1); check("dn_unf0_2", unf0, 0);
        step(); check("dn_q0_3", q0, 9); check("dn_unf0_3", unf0, 1); check("dn_tc0_3", tc0, 0);
        step(); check("dn_q0_4", q0, 8); check("dn_unf0_4", unf0, 0);
        check("dn_q1_4", q1, 5); check("dn_q2_4", q2, 8);

        // Load clamps above MAX_VAL and wins over enable.
        load = 1'b1; load_val = 8'd13; up_down = 1'b1;
        #1;
        check("ld_tc0", tc0, 0);
        step();
        check("ld13_q0", q0, 9); check("ld13_q1", q1, 9); check("ld13_q2", q2, 13);
        check("ld_tc0_at9", tc0, 0); check("ld_tc1_at9", tc1, 0);
        load_val = 8'd5;
        step();
        check("ld5_q0", q0, 5); check("ld5_ovf0", ovf0, 0); check("ld5_ovf1", ovf1, 0);
        check("ld5_q2", q2, 5);

        // Saturation from 8 upward: q1 9,9,9.
        load_val = 8'd8;
        step();
        check("ld8_q1", q1, 8);
        load = 1'b0;
        step(); check("sat_q1_1", q1, 9); check("sat_ovf1_1", ovf1, 0); check("sat_q0_1", q0, 9);
        step(); check("sat_q1_2", q1, 9); check("sat_ovf1_2", ovf1, 1);
        check("sat_q0_2", q0, 0); check("sat_ovf0_2", ovf0, 1);
        step(); check("sat_q1_3", q1, 9); check("sat_ovf1_3", ovf1, 1);
        check("sat_q0_3", q0, 1); check("sat_ovf0_3", ovf0, 0); check("sat_q2_3", q2, 11);

        // Down from 0: saturating holds, wrapping goes to MAX_VAL, wide wraps to 255.
        load = 1'b1; load_val = 8'd0;
        step();
        load = 1'b0; up_down = 1'b0;
        step();
        check("sdn_q1_1", q1, 0); check("sdn_unf1_1", unf1, 1); check("sdn_ovf1_1", ovf1, 0);
        check("sdn_q0_1", q0, 9); check("sdn_unf0_1", unf0, 1);
        check("sdn_q2_1", q2, 255); check("sdn_unf2_1", unf2, 1);
        step();
        check("sdn_q1_2", q1, 0); check("sdn_unf1_2", unf1, 1);
        check("sdn_q0_2", q0, 8); check("sdn_unf0_2", unf0, 0);
        check("sdn_q2_2", q2, 254); check("sdn_unf2_2", unf2, 0);

        // Reset on the at-limit up-step discards the step and its pulse.
        load = 1'b1; load_val = 8'd8; up_down = 1'b1;
        step();
        load = 1'b0;
        step();
        check("pre_rst_q0", q0, 9); check("pre_rst_tc0", tc0, 1);
        rst = 1'b0;
        step();
        check("mid_rst_q0", q0, 0); check("mid_rst_ovf0", ovf0, 0);
        check("mid_rst_q1", q1, 0); check("mid_rst_ovf1", ovf1, 0);
        check("mid_rst_q2", q2, 0);

        // Hold with en=0.
        rst = 1'b1; en = 1'b0; up_down = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_q0", q0, 0);
            check("hold_tc0", tc0, 0);
            check("hold_unf0", unf0, 0);
            check("hold_unf1", unf1, 0);
        end

        // Resume counting from 0.
        en = 1'b1; up_down = 1'b1;
        step();
        check("resume_q0", q0, 1); check("resume_q1", q1, 1); check("resume_q2", q2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
